// File: rtl/axi_lite_timer.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_timer
// Purpose  : AXI4-Lite 64-bit machine timer (mtime/mtimecmp), prescaler and
//            registered level compare interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_timer #(
    parameter int C_ADDR_WIDTH = 9,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C_ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [C_DATA_WIDTH-1:0]   wdata,
    input  logic [C_DATA_WIDTH/8-1:0] wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [C_ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [C_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      timer_irq
);

    localparam logic [2:0] c_MTIME_LO = 3'd0;
    localparam logic [2:0] c_MTIME_HI = 3'd1;
    localparam logic [2:0] c_CMP_LO   = 3'd2;
    localparam logic [2:0] c_CMP_HI   = 3'd3;
    localparam logic [2:0] c_CTRL     = 3'd4;
    localparam logic [2:0] c_PRESC    = 3'd5;
    localparam logic [1:0] c_OKAY     = 2'b00;
    localparam logic [1:0] c_SLVERR   = 2'b10;

    logic        r_aw_held, r_w_held, r_bvalid, r_rvalid, r_irq;
    logic [2:0]  r_aw_idx;
    logic [31:0] r_wdata, r_rdata, r_presc, r_pc, r_shadow;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp, r_rresp, r_ctrl;
    logic [63:0] r_mtime, r_cmp;

    logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic        w_do_write, w_tick, w_rd_err;
    logic [2:0]  w_ar_idx;
    logic [31:0] w_rd_data, w_wr_old, w_wr_val;
    logic        w_unused_ok;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    assign awready   = ~rst & ~r_aw_held & ~r_bvalid;
    assign wready    = ~rst & ~r_w_held & ~r_bvalid;
    assign arready   = ~rst & ~r_rvalid;
    assign bvalid    = r_bvalid;
    assign bresp     = r_bresp;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;
    assign rresp     = r_rresp;
    assign timer_irq = r_irq;

    assign w_aw_hs    = awvalid & awready;
    assign w_w_hs     = wvalid & wready;
    assign w_b_hs     = r_bvalid & bready;
    assign w_ar_hs    = arvalid & arready;
    assign w_r_hs     = r_rvalid & rready;
    assign w_do_write = r_aw_held & r_w_held & ~r_bvalid;
    assign w_tick     = r_ctrl[0] & (r_pc == r_presc);
    assign w_ar_idx   = araddr[4:2];
    assign w_wr_val   = f_merge(w_wr_old, r_wdata, r_wstrb);
    // Protection bits and address bits outside [4:2] are deliberately ignored.
    assign w_unused_ok = ^{awprot, arprot, awaddr, araddr};

    always_comb begin
        w_wr_old = '0;
        case (r_aw_idx)
            c_MTIME_LO: w_wr_old = r_mtime[31:0];
            c_MTIME_HI: w_wr_old = r_mtime[63:32];
            c_CMP_LO:   w_wr_old = r_cmp[31:0];
            c_CMP_HI:   w_wr_old = r_cmp[63:32];
            c_CTRL:     w_wr_old = {30'd0, r_ctrl};
            c_PRESC:    w_wr_old = r_presc;
            default:    w_wr_old = '0;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (w_ar_idx)
            c_MTIME_LO: w_rd_data = r_mtime[31:0];
            c_MTIME_HI: w_rd_data = r_shadow;
            c_CMP_LO:   w_rd_data = r_cmp[31:0];
            c_CMP_HI:   w_rd_data = r_cmp[63:32];
            c_CTRL:     w_rd_data = {30'd0, r_ctrl};
            c_PRESC:    w_rd_data = r_presc;
            default:    w_rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_OKAY;
            r_shadow  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= awaddr[4:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            if (w_b_hs) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else if (w_do_write) begin
                r_bvalid <= 1'b1;
                r_bresp  <= (r_aw_idx > c_PRESC) ? c_SLVERR : c_OKAY;
            end
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_err ? c_SLVERR : c_OKAY;
                if (w_ar_idx == c_MTIME_LO) r_shadow <= r_mtime[63:32];
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime <= '0;
            r_cmp   <= '1;
            r_ctrl  <= '0;
            r_presc <= '0;
            r_pc    <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
                r_pc    <= '0;
            end else if (r_ctrl[0]) begin
                r_pc <= r_pc + 32'd1;
            end
            // A write to either mtime half replaces the whole vector, so the
            // untouched half keeps its pre-tick value and the increment is lost.
            if (w_do_write) begin
                case (r_aw_idx)
                    c_MTIME_LO: r_mtime <= {r_mtime[63:32], w_wr_val};
                    c_MTIME_HI: r_mtime <= {w_wr_val, r_mtime[31:0]};
                    c_CMP_LO:   r_cmp[31:0]  <= w_wr_val;
                    c_CMP_HI:   r_cmp[63:32] <= w_wr_val;
                    c_CTRL:     r_ctrl <= w_wr_val[1:0];
                    c_PRESC: begin
                        r_presc <= w_wr_val;
                        r_pc    <= '0;
                    end
                    default: ;
                endcase
            end
            r_irq <= r_ctrl[1] & (r_mtime >= r_cmp);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_timer
// Purpose  : Directed self-checking bench for axi_lite_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_timer;

    localparam logic [8:0] c_MTIME_LO = 9'h00;
    localparam logic [8:0] c_MTIME_HI = 9'h04;
    localparam logic [8:0] c_CMP_LO   = 9'h08;
    localparam logic [8:0] c_CMP_HI   = 9'h0C;
    localparam logic [8:0] c_CTRL     = 9'h10;
    localparam logic [8:0] c_PRESC    = 9'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, timer_irq;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_lite_timer #(.C_ADDR_WIDTH(9), .C_DATA_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .timer_irq(timer_irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly,
                             input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0;
        w_done  = 0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        for (n = 0; n < 50 && !(aw_done && w_done); n++) begin
            awvalid = (n >= aw_dly) && !aw_done;
            wvalid  = (n >= w_dly) && !w_done;
            if (aw_done) chk("aw_blocked", awready, 0);
            if (w_done)  chk("w_blocked", wready, 0);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk);
            #1;
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
        end
        awvalid = 0;
        wvalid  = 0;
        if (!(aw_done && w_done)) chk("wr_accept_timeout", 0, 1);
        for (n = 0; n < 50 && !bvalid; n++) idle(1);
        if (!bvalid) chk("bvalid_timeout", 0, 1);
        for (int i = 0; i < b_dly; i++) begin
            chk("bvalid_hold", {awready, wready, bvalid}, 3'b001);
            idle(1);
        end
        resp   = bresp;
        bready = 1;
        idle(1);
        bready = 0;
    endtask

    task automatic axi_read(input logic [8:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        bit done;
        int n;
        araddr  = addr;
        arvalid = 1;
        done    = 0;
        for (n = 0; n < 50 && !done; n++) begin
            done = arready;
            idle(1);
        end
        arvalid = 0;
        for (n = 0; n < 50 && !rvalid; n++) idle(1);
        if (!rvalid) chk("rvalid_timeout", 0, 1);
        data = rdata;
        resp = rresp;
        for (int i = 0; i < r_dly; i++) begin
            chk("rdata_stable", {rvalid, rdata, rresp}, {1'b1, data, resp});
            idle(1);
        end
        rready = 1;
        idle(1);
        rready = 0;
    endtask

    task automatic wr(input logic [8:0] addr, input logic [31:0] data);
        logic [1:0] resp;
        axi_write(addr, data, 4'hF, 0, 0, 0, resp);
        chk("wr_bresp", resp, 2'b00);
    endtask

    task automatic rd(input string tag, input logic [8:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  resp;
        axi_read(addr, 0, d, resp);
        chk(tag, {resp, d}, {2'b00, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, d;
        logic [1:0]  resp;
        int k;

        rst = 1; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0;
        wvalid = 0; bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;
        idle(3);
        chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, timer_irq}, 6'b0);
        rst = 0;
        idle(1);

        // 1: reset values
        rd("rst_cmp_lo", c_CMP_LO, 32'hFFFF_FFFF);
        rd("rst_cmp_hi", c_CMP_HI, 32'hFFFF_FFFF);
        chk("rst_irq", timer_irq, 0);
        rd("rst_mtime_lo", c_MTIME_LO, 32'h0);

        // 2: prescaled and undivided count rates
        wr(c_PRESC, 32'd3);
        wr(c_CTRL, 32'd1);
        axi_read(c_MTIME_LO, 0, a, resp);
        idle(38);
        axi_read(c_MTIME_LO, 0, b, resp);
        chk("presc3_rate", b - a, 32'd10);
        wr(c_PRESC, 32'd0);
        axi_read(c_MTIME_LO, 0, a, resp);
        idle(8);
        axi_read(c_MTIME_LO, 0, b, resp);
        chk("presc0_rate", b - a, 32'd10);

        // 3: carry into the high word, high read comes from the shadow
        wr(c_CTRL, 32'd0);
        wr(c_MTIME_LO, 32'hFFFF_FFFE);
        wr(c_MTIME_HI, 32'd0);
        wr(c_PRESC, 32'd0);
        wr(c_CTRL, 32'd1);
        idle(3);
        rd("wrap_lo", c_MTIME_LO, 32'd2);
        rd("wrap_hi_shadow", c_MTIME_HI, 32'd1);

        // 4: compare interrupt
        wr(c_CTRL, 32'd0);
        wr(c_MTIME_LO, 32'd0);
        wr(c_MTIME_HI, 32'd0);
        wr(c_CMP_LO, 32'd100);
        wr(c_CMP_HI, 32'd0);
        chk("irq_masked", timer_irq, 0);
        wr(c_CTRL, 32'd3);
        k = 0;
        while (!timer_irq && k < 300) begin
            idle(1);
            k++;
        end
        chk("irq_rise_cycle", k, 100);
        wr(c_CMP_LO, 32'hFFFF_FFFF);
        chk("irq_fall", timer_irq, 0);

        // 5: channel ordering, byte strobes, held response
        wr(c_CTRL, 32'd0);
        axi_write(c_CMP_LO, 32'h1111_1111, 4'hF, 0, 3, 5, resp);
        chk("aw_first_bresp", resp, 2'b00);
        axi_write(c_CMP_HI, 32'h2222_2222, 4'hF, 2, 0, 2, resp);
        chk("w_first_bresp", resp, 2'b00);
        axi_write(c_CMP_LO, 32'hAABB_CCDD, 4'b0010, 0, 0, 0, resp);
        chk("strb_bresp", resp, 2'b00);
        rd("strb_cmp_lo", c_CMP_LO, 32'h1111_CC11);
        rd("w_first_cmp_hi", c_CMP_HI, 32'h2222_2222);
        rd("upper_addr_ignored", 9'h10C, 32'h2222_2222);

        // 6: undecoded offsets, reset mid-transaction
        axi_read(9'h018, 3, d, resp);
        chk("rd_bad_addr", {resp, d}, {2'b10, 32'h0});
        axi_write(9'h01C, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp);
        chk("wr_bad_bresp", resp, 2'b10);
        rd("bad_wr_no_change", c_CMP_LO, 32'h1111_CC11);
        wr(c_PRESC, 32'd5);
        wr(c_CTRL, 32'd1);
        awaddr = c_CMP_LO;
        awvalid = 1;
        idle(1);
        awvalid = 0;
        chk("aw_held_pre_rst", awready, 0);
        rst = 1;
        wdata = 32'h1234_5678;
        wstrb = 4'hF;
        wvalid = 1;
        idle(1);
        rst = 0;
        wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("no_bvalid_after_rst", bvalid, 0);
            idle(1);
        end
        rd("rst2_cmp_lo", c_CMP_LO, 32'hFFFF_FFFF);
        rd("rst2_ctrl", c_CTRL, 32'h0);
        rd("rst2_presc", c_PRESC, 32'h0);
        rd("rst2_mtime_lo", c_MTIME_LO, 32'h0);
        rd("rst2_mtime_hi", c_MTIME_HI, 32'h0);
        chk("rst2_irq", timer_irq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
